// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan.
// Segment vectors are active low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic {
        SHOW,
        BLANK
    } scanState_t;

    localparam logic [1:0] D1_IDX = 2'd0;
    localparam logic [1:0] D2_IDX = 2'd1;
    localparam logic [1:0] D3_IDX = 2'd2;
    localparam logic [1:0] D4_IDX = 2'd3;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    localparam logic [6:0] SEG_GLYPH [10] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 render as a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_GLYPH[bcd];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment scanner with inter-digit blanking and frame-coherent digit capture.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits D2..D4.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_W        = 8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        refreshTick,
    input  logic [15:0] digitsIn,
    input  logic [3:0]  dpIn,
    input  logic        digitsValid,
    output logic        digitsAck,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frameStart
);

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

    scanState_t       state, stateNext;
    logic [1:0]       idx, idxNext;
    logic [CNT_W-1:0] blankCnt, blankCntNext;
    logic [15:0]      shadowDigits, shadowDigitsNext;
    logic [3:0]       shadowDp, shadowDpNext;
    logic             frameEntry;
    logic             captureNow;
    logic [3:0]       muxDigit;
    logic [6:0]       glyph;
    logic [3:0]       anNext;
    logic [6:0]       segNext;
    logic             dpNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SHOW;
            idx          <= D4_IDX;
            blankCnt     <= '0;
            shadowDigits <= '0;
            shadowDp     <= '0;
        end else begin
            state        <= stateNext;
            idx          <= idxNext;
            blankCnt     <= blankCntNext;
            shadowDigits <= shadowDigitsNext;
            shadowDp     <= shadowDpNext;
        end
    end

    // Capture is only allowed on the edge that enters SHOW at D1, so a frame never tears.
    always_comb begin
        stateNext        = state;
        idxNext          = idx;
        blankCntNext     = blankCnt;
        shadowDigitsNext = shadowDigits;
        shadowDpNext     = shadowDp;
        frameEntry       = 1'b0;
        captureNow       = 1'b0;
        case (state)
            SHOW: begin
                if (refreshTick) begin
                    if (BLANK_CYCLES == 0) begin
                        idxNext    = idx + 2'd1;
                        frameEntry = (idx == D4_IDX);
                    end else begin
                        stateNext    = BLANK;
                        blankCntNext = BLANK_LOAD;
                    end
                end
            end
            BLANK: begin
                blankCntNext = blankCnt - CNT_W'(1);
                if (blankCnt <= CNT_W'(1)) begin
                    stateNext    = SHOW;
                    idxNext      = idx + 2'd1;
                    blankCntNext = '0;
                    frameEntry   = (idx == D4_IDX);
                end
            end
            default: stateNext = SHOW;
        endcase
        if (frameEntry && digitsValid) begin
            shadowDigitsNext = digitsIn;
            shadowDpNext     = dpIn;
            captureNow       = 1'b1;
        end
    end

    assign muxDigit = shadowDigitsNext[{idxNext, 2'b00} +: 4];

    bcd_to_seg u_decode (
        .bcd (muxDigit),
        .seg (glyph)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [3:0] zeroFrom;

    always_comb begin
        zeroFrom[0] = 1'b0;
        zeroFrom[1] = (shadowDigitsNext[15:4] == 12'd0);
        zeroFrom[2] = (shadowDigitsNext[15:8] == 8'd0);
        zeroFrom[3] = (shadowDigitsNext[15:12] == 4'd0);
    end
`endif

    // Outputs are computed from next-state values so the registered pins line up with the state.
    always_comb begin
        anNext  = AN_ALL_OFF;
        segNext = SEG_BLANK;
        dpNext  = 1'b1;
        if (stateNext == SHOW) begin
            anNext  = ~(4'b0001 << idxNext);
            segNext = glyph;
            dpNext  = ~shadowDpNext[idxNext];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (idxNext != D1_IDX && zeroFrom[idxNext]) begin
                segNext = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= AN_ALL_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            digitsAck  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            an         <= anNext;
            seg        <= segNext;
            dp         <= dpNext;
            digitsAck  <= captureNow;
            frameStart <= frameEntry;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a timeline model of the scan checked every cycle, a frame table,
// and hand sequences for blanking, dropped ticks, zero-gap scanning and async reset.
module tb_seg_scan_driver;

    localparam int B = 4;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_ZERO = 7'b1111111;
`else
    localparam logic [6:0] LEAD_ZERO = 7'b1000000;
`endif
    localparam logic [6:0] DASH = 7'b0111111;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dps;
        logic [3:0][6:0] segExp;
        logic [3:0]      dpExp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        refreshTick;
    logic [15:0] digitsIn;
    logic [3:0]  dpIn;
    logic        digitsValid;
    logic        digitsAck;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frameStart;

    logic        tick0;
    logic        valid0;
    logic [15:0] digits0;
    logic [3:0]  dps0;
    logic        ack0;
    logic [3:0]  an0;
    logic [6:0]  seg0;
    logic        dpOut0;
    logic        fs0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tickPeriod = -1;
    bit randomWriter = 1'b0;
    bit writerHold = 1'b0;
    int modelAcks = 0;

    int         mPos;
    bit         mBlanking;
    int         mShowAt;
    int         mShadow [4];
    bit         mShadowDp [4];
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    logic       eAck;
    logic       eFs;

    always #5 clk = ~clk;

    seg_scan_driver #(.BLANK_CYCLES(B), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .refreshTick (refreshTick),
        .digitsIn    (digitsIn),
        .dpIn        (dpIn),
        .digitsValid (digitsValid),
        .digitsAck   (digitsAck),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frameStart  (frameStart)
    );

    seg_scan_driver #(.BLANK_CYCLES(0), .CNT_W(8)) dutNoGap (
        .clk         (clk),
        .reset       (reset),
        .refreshTick (tick0),
        .digitsIn    (digits0),
        .dpIn        (dps0),
        .digitsValid (valid0),
        .digitsAck   (ack0),
        .an          (an0),
        .seg         (seg0),
        .dp          (dpOut0),
        .frameStart  (fs0)
    );

    function automatic logic [6:0] glyphOf(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    function automatic logic [6:0] expectedSeg(int pos);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        bit leadingZero = (pos > 0);
        for (int k = pos; k < 4; k++) begin
            if (mShadow[k] != 0) leadingZero = 1'b0;
        end
        if (leadingZero) return 7'b1111111;
`endif
        return glyphOf(mShadow[pos]);
    endfunction

    task automatic modelReset();
        mPos      = 3;
        mBlanking = 1'b0;
        mShowAt   = 0;
        for (int k = 0; k < 4; k++) begin
            mShadow[k]   = 0;
            mShadowDp[k] = 1'b0;
        end
        eAn  = 4'b1111;
        eSeg = 7'b1111111;
        eDp  = 1'b1;
        eAck = 1'b0;
        eFs  = 1'b0;
    endtask

    // One clock edge of the scan expressed as a timeline: a tick starts a gap that ends at a known cycle.
    task automatic modelEdge();
        bit entry = 1'b0;
        eAck = 1'b0;
        eFs  = 1'b0;
        if (mBlanking) begin
            if (cyc == mShowAt - 1) begin
                mBlanking = 1'b0;
                entry     = 1'b1;
            end
        end else if (refreshTick) begin
            mPos = (mPos + 1) % 4;
            if (B == 0) begin
                entry = 1'b1;
            end else begin
                mBlanking = 1'b1;
                mShowAt   = cyc + 1 + B;
            end
        end
        if (entry && mPos == 0) begin
            eFs = 1'b1;
            if (digitsValid) begin
                for (int k = 0; k < 4; k++) begin
                    mShadow[k]   = int'(digitsIn[4*k +: 4]);
                    mShadowDp[k] = dpIn[k];
                end
                eAck = 1'b1;
                modelAcks++;
            end
        end
        if (mBlanking) begin
            eAn  = 4'b1111;
            eSeg = 7'b1111111;
            eDp  = 1'b1;
        end else begin
            eAn  = ~(4'b0001 << mPos);
            eSeg = expectedSeg(mPos);
            eDp  = ~mShadowDp[mPos];
        end
    endtask

    task automatic checkOutput(string name);
        tests++;
        if ({an, seg, dp, digitsAck, frameStart} !== {eAn, eSeg, eDp, eAck, eFs}) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got an=%b seg=%b dp=%b ack=%b fs=%b, expected an=%b seg=%b dp=%b ack=%b fs=%b",
                     name, cyc, an, seg, dp, digitsAck, frameStart, eAn, eSeg, eDp, eAck, eFs);
        end
    endtask

    task automatic checkValue(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic randomDigits();
        digitsIn = 16'($urandom);
        dpIn     = 4'($urandom);
    endtask

    // Advances one clock, checks the scan against the model, then drives the writer and tick source.
    task automatic applyStimulus();
        @(posedge clk);
        if (reset) modelReset();
        else modelEdge();
        cyc++;
        @(negedge clk);
        checkOutput("scan");
        if (digitsValid && digitsAck) begin
            if (writerHold) randomDigits();
            else digitsValid = 1'b0;
        end else if (!digitsValid && randomWriter && $urandom_range(0, 3) == 0) begin
            randomDigits();
            digitsValid = 1'b1;
        end
        if (tickPeriod > 0) refreshTick = (cyc % tickPeriod == 0);
        else if (tickPeriod == 0) refreshTick = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [5];
        int gap;
        int waited;
        int ackCount;
        int ackStart;

        vecs[0] = '{16'h1234, 4'b0100, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
        vecs[1] = '{16'h00AF, 4'b0000, {LEAD_ZERO, LEAD_ZERO, DASH, DASH}, 4'b1111};
        vecs[2] = '{16'h9087, 4'b1001, {7'b0010000, 7'b1000000, 7'b0000000, 7'b1111000}, 4'b0110};
        vecs[3] = '{16'h0005, 4'b0010, {LEAD_ZERO, LEAD_ZERO, LEAD_ZERO, 7'b0010010}, 4'b1101};
        vecs[4] = '{16'h6000, 4'b1000, {7'b0000010, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0111};

        reset       = 1'b1;
        refreshTick = 1'b0;
        digitsIn    = '0;
        dpIn        = '0;
        digitsValid = 1'b0;
        tick0       = 1'b0;
        valid0      = 1'b0;
        digits0     = 16'h1234;
        dps0        = 4'b0100;
        modelReset();
        #1;
        checkOutput("reset_state");
        repeat (3) applyStimulus();
        reset = 1'b0;
        applyStimulus();
        checkValue("post_reset_an", 32'(an), 32'(4'b0111));

        // Zero-gap instance: anode moves one cycle after the tick with no all-off cycle.
        checkValue("nogap_idle_an", 32'(an0), 32'(4'b0111));
        valid0 = 1'b1;
        tick0  = 1'b1;
        applyStimulus();
        tick0 = 1'b0;
        checkValue("nogap_d1_an", 32'(an0), 32'(4'b1110));
        checkValue("nogap_frame_ack", 32'({fs0, ack0}), 32'(2'b11));
        checkValue("nogap_d1_seg", 32'({seg0, dpOut0}), 32'({7'b0011001, 1'b1}));
        valid0 = 1'b0;
        applyStimulus();
        checkValue("nogap_pulse_end", 32'({fs0, ack0}), 32'(2'b00));
        tick0 = 1'b1;
        applyStimulus();
        tick0 = 1'b0;
        checkValue("nogap_d2_an", 32'(an0), 32'(4'b1101));
        checkValue("nogap_d2_seg", 32'({seg0, dpOut0}), 32'({7'b0110000, 1'b1}));

        // Blank gap length, with a second tick inside the gap that must be dropped.
        refreshTick = 1'b1;
        applyStimulus();
        refreshTick = 1'b0;
        gap = 0;
        for (int i = 0; i < 20 && an == 4'b1111; i++) begin
            gap++;
            if (gap == 2) refreshTick = 1'b1;
            applyStimulus();
            refreshTick = 1'b0;
        end
        checkValue("blank_gap_len", 32'(gap), 32'(B));
        checkValue("d1_after_gap", 32'(an), 32'(4'b1110));
        repeat (10) applyStimulus();
        checkValue("dropped_tick_no_advance", 32'(an), 32'(4'b1110));

        // Frame table: valid raised mid-frame, ack on the next D1 entry, every digit checked.
        tickPeriod = 10;
        writerHold = 1'b0;
        for (int v = 0; v < 5; v++) begin
            digitsIn    = vecs[v].digits;
            dpIn        = vecs[v].dps;
            digitsValid = 1'b1;
            waited = 0;
            while (!digitsAck && waited < 200) begin
                applyStimulus();
                waited++;
            end
            checkValue("ack_wait", 32'(waited < 200), 32'd1);
            checkValue("ack_with_frame", 32'({digitsAck, frameStart, an}), 32'({2'b11, 4'b1110}));
            for (int k = 0; k < 4; k++) begin
                waited = 0;
                while (an != ~(4'b0001 << k) && waited < 100) begin
                    applyStimulus();
                    waited++;
                end
                checkValue("table_digit", 32'({seg, dp}), 32'({vecs[v].segExp[k], vecs[v].dpExp[k]}));
            end
        end

        // Valid held across frames, value changed after every ack.
        writerHold = 1'b1;
        randomDigits();
        digitsValid = 1'b1;
        ackCount = 0;
        ackStart = modelAcks;
        repeat (200) begin
            applyStimulus();
            ackCount += int'(digitsAck);
        end
        checkValue("one_ack_per_frame", 32'(ackCount), 32'(modelAcks - ackStart));
        checkValue("frames_in_window", 32'(modelAcks - ackStart >= 4), 32'd1);

        // Async reset in the middle of a blank gap with a capture still pending.
        writerHold  = 1'b0;
        tickPeriod  = -1;
        refreshTick = 1'b0;
        digitsValid = 1'b0;
        repeat (10) applyStimulus();
        randomDigits();
        digitsValid = 1'b1;
        refreshTick = 1'b1;
        applyStimulus();
        refreshTick = 1'b0;
        applyStimulus();
        #2 reset = 1'b1;
        #1;
        checkValue("async_reset_outputs", 32'({an, seg, dp, digitsAck, frameStart}),
                   32'({4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}));
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        tickPeriod = 7;
        waited = 0;
        while (!digitsAck && waited < 200) begin
            applyStimulus();
            waited++;
        end
        checkValue("ack_after_reset", 32'({digitsAck, frameStart, an}), 32'({2'b11, 4'b1110}));

        // Randomized ticks and writer traffic against the model.
        tickPeriod   = 0;
        randomWriter = 1'b1;
        repeat (1500) begin
            applyStimulus();
            writerHold = 1'($urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
